// File: rtl/miriscv_defines.sv
// Shared miriscv definitions: load/store size codes (funct3), LSU FSM state
// encoding, and the helper that maps a byte address to an access lane.
package miriscv_defines;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Lane offset actually used by an access: offset bits below the access
  // size are dropped, and word (or undefined) sizes always use lane 0.
  function automatic logic [1:0] lsu_lane_offset(input logic [1:0] addr,
                                                  input logic [2:0] size);
    logic [1:0] lane;
    case (size)
      LDST_B, LDST_BU: lane = addr;
      LDST_H, LDST_HU: lane = {addr[1], 1'b0};
      default:         lane = 2'b00;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/miriscv_lsu_ext.sv
// Load data lane select and sign/zero extension (purely combinational).
module miriscv_lsu_ext
  import miriscv_defines::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed byte / halfword out of the returned word and extend it.
  always_comb begin
    case (offset_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      LDST_B:  data_o = {{24{byte_lane[7]}}, byte_lane};
      LDST_BU: data_o = {24'd0, byte_lane};
      LDST_H:  data_o = {{16{half_lane[15]}}, half_lane};
      LDST_HU: data_o = {16'd0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: drives the req/gnt/rvalid data-memory handshake,
// stalls the core until the access completes and returns extended load data.
// Optional feature: define MIRISCV_LSU_MISALIGN_EXC_EN to trap misaligned
// H/HU/W accesses (no memory request, one-cycle lsu_misalign_o pulse).
module miriscv_lsu
  import miriscv_defines::*;
(
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e  state_q;
  logic [1:0]  offset_q;
  logic [2:0]  size_q;
  logic        we_q;

  logic [1:0]  lane;
  logic        misalign;
  logic        done;
  logic [31:0] ext_data;

  assign lane = lsu_lane_offset(lsu_addr_i[1:0], lsu_size_i);

`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
  // A misaligned request is caught in IDLE, before anything reaches memory.
  assign misalign = (state_q == IDLE) & lsu_req_i &
                    ((((lsu_size_i == LDST_H) | (lsu_size_i == LDST_HU)) & lsu_addr_i[0]) |
                     ((lsu_size_i == LDST_W) & (lsu_addr_i[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign done            = (state_q == RESP) & data_rvalid_i;
  assign data_req_o      = arstn_i & lsu_req_i & ~misalign & (state_q != RESP);
  assign lsu_stall_req_o = arstn_i & lsu_req_i & ~misalign & ~done;
  assign lsu_misalign_o  = arstn_i & misalign;

  assign data_addr_o = {lsu_addr_i[31:2], 2'b00};
  assign data_we_o   = lsu_we_i;

  // Byte enables and replicated store data from the live core inputs.
  always_comb begin
    case (lsu_size_i)
      LDST_B, LDST_BU: begin
        data_be_o    = 4'b0001 << lane;
        data_wdata_o = {4{lsu_data_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        data_be_o    = 4'b0011 << lane;
        data_wdata_o = {2{lsu_data_i[15:0]}};
      end
      default: begin
        data_be_o    = 4'b1111;
        data_wdata_o = lsu_data_i;
      end
    endcase
  end

  // Handshake FSM; access attributes are latched at the granting edge.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= IDLE;
      offset_q <= 2'b00;
      size_q   <= 3'd0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req_o) begin
            if (data_gnt_i) begin
              state_q  <= RESP;
              offset_q <= lane;
              size_q   <= lsu_size_i;
              we_q     <= lsu_we_i;
            end else begin
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            state_q  <= RESP;
            offset_q <= lane;
            size_q   <= lsu_size_i;
            we_q     <= lsu_we_i;
          end
        end
        RESP: begin
          if (data_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  miriscv_lsu_ext u_ext (
    .rdata_i  (data_rdata_i),
    .offset_i (offset_q),
    .size_i   (size_q),
    .data_o   (ext_data)
  );

  assign lsu_data_o = (done & ~we_q) ? ext_data : 32'd0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: table of single-access vectors plus
// hand-written delayed-grant, back-to-back, reset and misalign sequences.
module tb_miriscv_lsu;
  import miriscv_defines::*;

  logic        clk = 1'b0;
  logic        arstn;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        stall, misal;
  logic [31:0] lsu_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  miriscv_lsu dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .lsu_req_i       (lsu_req),
    .lsu_we_i        (lsu_we),
    .lsu_size_i      (lsu_size),
    .lsu_addr_i      (lsu_addr),
    .lsu_data_i      (lsu_wdata),
    .lsu_stall_req_o (stall),
    .lsu_data_o      (lsu_rdata),
    .lsu_misalign_o  (misal),
    .data_req_o      (d_req),
    .data_we_o       (d_we),
    .data_be_o       (d_be),
    .data_addr_o     (d_addr),
    .data_wdata_o    (d_wdata),
    .data_gnt_i      (d_gnt),
    .data_rvalid_i   (d_rvalid),
    .data_rdata_i    (d_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Advance to just after the next rising edge, ready to drive inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive at edge+1, sample at edge+5 (falling edge).
  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    lsu_req = 1'b0; d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = 32'd0;
  endtask

  task automatic drive_access(input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wd);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wd;
  endtask

  initial begin
    int stall_cycles;

    vecs[0]  = '{1'b1, LDST_B,  32'h0000_1003, 32'h0000_00A5, 32'h0,         4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, 32'h0};
    vecs[1]  = '{1'b0, LDST_B,  32'h0000_2001, 32'h0,         32'h0000_8000, 4'b0010, 32'h0,         32'h0000_2000, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, LDST_BU, 32'h0000_2001, 32'h0,         32'h0000_8000, 4'b0010, 32'h0,         32'h0000_2000, 32'h0000_0080};
    vecs[3]  = '{1'b0, LDST_H,  32'h0000_2002, 32'h0,         32'h8001_1234, 4'b1100, 32'h0,         32'h0000_2000, 32'hFFFF_8001};
    vecs[4]  = '{1'b0, LDST_HU, 32'h0000_2000, 32'h0,         32'h8001_F234, 4'b0011, 32'h0,         32'h0000_2000, 32'h0000_F234};
    vecs[5]  = '{1'b1, LDST_H,  32'h0000_1002, 32'h1234_5678, 32'h0,         4'b1100, 32'h5678_5678, 32'h0000_1000, 32'h0};
    vecs[6]  = '{1'b1, LDST_W,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0,         4'b1111, 32'hDEAD_BEEF, 32'h0000_1004, 32'h0};
    vecs[7]  = '{1'b0, LDST_W,  32'h0000_2008, 32'h0,         32'hCAFE_F00D, 4'b1111, 32'h0,         32'h0000_2008, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, LDST_B,  32'h0000_2003, 32'h0,         32'h7F00_0000, 4'b1000, 32'h0,         32'h0000_2000, 32'h0000_007F};
    vecs[9]  = '{1'b0, 3'd3,    32'h0000_2000, 32'h0,         32'h89AB_CDEF, 4'b1111, 32'h0,         32'h0000_2000, 32'h89AB_CDEF};
    vecs[10] = '{1'b0, LDST_B,  32'h0000_2000, 32'h0,         32'h0000_00FF, 4'b0001, 32'h0,         32'h0000_2000, 32'hFFFF_FFFF};

    // Reset state, with a pending core request that must stay gated.
    arstn = 1'b0;
    idle_inputs();
    drive_access(1'b0, LDST_W, 32'h0000_2000, 32'h0);
    #3;
    check("rst data_req", 32'(d_req), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst misalign", 32'(misal), 32'd0);
    check("rst lsu_data", lsu_rdata, 32'd0);
    d_rvalid = 1'b1; d_rdata = 32'hFFFF_FFFF;
    next_cycle();
    next_cycle();
    idle_inputs();
    arstn = 1'b1;
    // Stray response after reset is ignored.
    d_rvalid = 1'b1; d_rdata = 32'h1234_5678;
    settle();
    check("stray rvalid lsu_data", lsu_rdata, 32'd0);
    check("stray rvalid stall", 32'(stall), 32'd0);

    // Table: immediate grant, rvalid the next cycle.
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      idle_inputs();
      drive_access(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      d_gnt = 1'b1;
      settle();
      check($sformatf("v%0d data_req", i), 32'(d_req), 32'd1);
      check($sformatf("v%0d be", i), 32'(d_be), 32'(vecs[i].be));
      check($sformatf("v%0d addr", i), d_addr, vecs[i].exp_addr);
      check($sformatf("v%0d we", i), 32'(d_we), 32'(vecs[i].we));
      if (vecs[i].we) check($sformatf("v%0d wdata", i), d_wdata, vecs[i].exp_wdata);
      check($sformatf("v%0d stall c0", i), 32'(stall), 32'd1);
      next_cycle();
      d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = vecs[i].rdata;
      settle();
      check($sformatf("v%0d stall c1", i), 32'(stall), 32'd0);
      check($sformatf("v%0d data_req c1", i), 32'(d_req), 32'd0);
      check($sformatf("v%0d lsu_data", i), lsu_rdata, vecs[i].exp_data);
      next_cycle();
      idle_inputs();
      settle();
      check($sformatf("v%0d lsu_data idle", i), lsu_rdata, 32'd0);
    end

    // HU load, grant delayed 3 cycles, rvalid noise while still in REQ.
    stall_cycles = 0;
    next_cycle();
    idle_inputs();
    drive_access(1'b0, LDST_HU, 32'h0000_2002, 32'h0);
    for (int c = 0; c < 3; c++) begin
      d_gnt = 1'b0;
      d_rvalid = (c != 0);
      d_rdata = 32'hBEEF_0000;
      settle();
      if (stall) stall_cycles++;
      check($sformatf("hu wait%0d data_req", c), 32'(d_req), 32'd1);
      check($sformatf("hu wait%0d lsu_data", c), lsu_rdata, 32'd0);
      next_cycle();
    end
    d_gnt = 1'b1; d_rvalid = 1'b0;
    settle();
    if (stall) stall_cycles++;
    next_cycle();
    d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'hBEEF_0000;
    settle();
    if (stall) stall_cycles++;
    check("hu stall cycles", 32'(stall_cycles), 32'd4);
    check("hu lsu_data", lsu_rdata, 32'h0000_BEEF);

    // Back-to-back W loads: 4 cycles, second request right after completion.
    next_cycle();
    idle_inputs();
    drive_access(1'b0, LDST_W, 32'h0000_4000, 32'h0);
    d_gnt = 1'b1;
    settle();
    check("b2b c0 data_req", 32'(d_req), 32'd1);
    next_cycle();
    d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h1111_2222;
    settle();
    check("b2b c1 lsu_data", lsu_rdata, 32'h1111_2222);
    check("b2b c1 stall", 32'(stall), 32'd0);
    next_cycle();
    drive_access(1'b0, LDST_W, 32'h0000_4004, 32'h0);
    d_gnt = 1'b1; d_rvalid = 1'b0;
    settle();
    check("b2b c2 data_req", 32'(d_req), 32'd1);
    check("b2b c2 addr", d_addr, 32'h0000_4004);
    next_cycle();
    d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h3333_4444;
    settle();
    check("b2b c3 lsu_data", lsu_rdata, 32'h3333_4444);
    check("b2b c3 stall", 32'(stall), 32'd0);

    // Reset while in RESP, late rvalid afterwards.
    next_cycle();
    idle_inputs();
    drive_access(1'b0, LDST_W, 32'h0000_5000, 32'h0);
    d_gnt = 1'b1;
    next_cycle();
    d_gnt = 1'b0;
    arstn = 1'b0;
    settle();
    check("rst-resp data_req", 32'(d_req), 32'd0);
    check("rst-resp stall", 32'(stall), 32'd0);
    next_cycle();
    arstn = 1'b1;
    lsu_req = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h5555_AAAA;
    settle();
    check("late rvalid lsu_data", lsu_rdata, 32'd0);
    check("late rvalid stall", 32'(stall), 32'd0);
    next_cycle();
    drive_access(1'b0, LDST_W, 32'h0000_5008, 32'h0);
    d_gnt = 1'b0; d_rvalid = 1'b1;
    settle();
    check("post-rst idle data_req", 32'(d_req), 32'd1);
    check("post-rst idle lsu_data", lsu_rdata, 32'd0);
    next_cycle();
    d_gnt = 1'b1; d_rvalid = 1'b0;
    next_cycle();
    d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h0BAD_F00D;
    settle();
    check("post-rst load lsu_data", lsu_rdata, 32'h0BAD_F00D);

    // Misaligned W load from 0x3002.
    next_cycle();
    idle_inputs();
    drive_access(1'b0, LDST_W, 32'h0000_3002, 32'h0);
`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
    settle();
    check("misal data_req", 32'(d_req), 32'd0);
    check("misal pulse", 32'(misal), 32'd1);
    check("misal stall", 32'(stall), 32'd0);
    check("misal lsu_data", lsu_rdata, 32'd0);
    next_cycle();
    idle_inputs();
    settle();
    check("misal pulse end", 32'(misal), 32'd0);
`else
    d_gnt = 1'b1;
    settle();
    check("unal data_req", 32'(d_req), 32'd1);
    check("unal be", 32'(d_be), 32'hF);
    check("unal addr", d_addr, 32'h0000_3000);
    check("unal misalign", 32'(misal), 32'd0);
    next_cycle();
    d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 32'h1122_3344;
    settle();
    check("unal lsu_data", lsu_rdata, 32'h1122_3344);
    next_cycle();
    idle_inputs();
`endif

    next_cycle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
